// File: rtl/regfile_mp.sv
// Multi-port integer register file with a sequential clear engine.
// x0 is hard-wired to zero and never stored. After reset or a clear request
// one entry per cycle is zeroed, so the array needs no reset and can map to
// distributed RAM. Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int unsigned NumRegs       = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 5,
  parameter int unsigned NumReadPorts  = 2,
  parameter int unsigned NumWritePorts = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clr_i,
  output logic                                  ready_o,
  input  logic [NumWritePorts-1:0]              wr_en_i,
  input  logic [NumWritePorts*AddressWidth-1:0] wr_addr_i,
  input  logic [NumWritePorts*DataWidth-1:0]    wr_data_i,
  input  logic [NumReadPorts*AddressWidth-1:0]  rd_addr_i,
  output logic [NumReadPorts*DataWidth-1:0]     rd_data_o
);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e                  r_state, w_state_next;
  logic [AddressWidth-1:0] r_clr_cnt, w_clr_cnt_next;
  logic                    w_clr_last;
  logic [DataWidth-1:0]    r_mem [NumRegs];

  assign w_clr_last = (r_clr_cnt == AddressWidth'(NumRegs - 1));
  assign ready_o    = (r_state == StIdle);

  // Next-state logic for the clear engine.
  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    unique case (r_state)
      StClear: begin
        // clr_i is ignored here: an in-progress clear never restarts.
        w_clr_cnt_next = r_clr_cnt + AddressWidth'(1);
        if (w_clr_last) w_state_next = StIdle;
      end
      StIdle: begin
        if (clr_i) begin
          w_state_next   = StClear;
          w_clr_cnt_next = AddressWidth'(1);
        end
      end
      default: begin
        w_state_next   = StClear;
        w_clr_cnt_next = AddressWidth'(1);
      end
    endcase
  end

  // State and clear-counter registers; reset restarts the clear at entry 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= StClear;
      r_clr_cnt <= AddressWidth'(1);
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
    end
  end

  // Array update: clear one entry per cycle, or perform port writes (later port wins).
  always_ff @(posedge clk_i) begin
    if (r_state == StClear) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      for (int unsigned p = 0; p < NumWritePorts; p++) begin
        if (wr_en_i[p] && (wr_addr_i[p*AddressWidth +: AddressWidth] != '0)) begin
          r_mem[wr_addr_i[p*AddressWidth +: AddressWidth]] <= wr_data_i[p*DataWidth +: DataWidth];
        end
      end
    end
  end

  // Combinational read ports; everything reads as zero while clearing.
  always_comb begin
    rd_data_o = '0;
    for (int unsigned r = 0; r < NumReadPorts; r++) begin
      logic [AddressWidth-1:0] w_addr;
      logic [DataWidth-1:0]    w_data;
      w_addr = rd_addr_i[r*AddressWidth +: AddressWidth];
      w_data = '0;
      if ((r_state == StIdle) && (w_addr != '0)) begin
        w_data = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
        // Higher-numbered write ports override, matching write priority.
        for (int unsigned p = 0; p < NumWritePorts; p++) begin
          if (wr_en_i[p] && (wr_addr_i[p*AddressWidth +: AddressWidth] == w_addr)) begin
            w_data = wr_data_i[p*DataWidth +: DataWidth];
          end
        end
`endif
      end
      rd_data_o[r*DataWidth +: DataWidth] = w_data;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (2 read ports, 2 write ports).
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        ready;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;

  regfile_mp #(
    .NumRegs      (32),
    .DataWidth    (32),
    .AddressWidth (5),
    .NumReadPorts (2),
    .NumWritePorts(2)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (clr),
    .ready_o  (ready),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;  // 0 ready, 1 rd port 0, 2 rd port 1
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.kind)
        0:       act = {31'b0, ready};
        1:       act = rd_data[31:0];
        default: act = rd_data[63:32];
      endcase
      n_checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        n_err++;
        $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int kind, input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.exp  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*5 +: 5]   = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a0, input logic [31:0] e0,
                        input logic [4:0] a1, input logic [31:0] e1);
    rd_addr = {a1, a0};
    expect_out({name, "_rd0"}, 1, e0);
    expect_out({name, "_rd1"}, 2, e1);
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < 16; i++) begin
      logic [4:0] a0, a1;
      step();
      a0 = 5'(2 * i);
      a1 = 5'(2 * i + 1);
      rd_chk(name, a0, 32'h0, a1, 32'h0);
    end
  endtask

  // Called in the first low window: expects 31 low windows, then ready high.
  task automatic run_clear(input string name, input int wr_at, input int clr_at);
    for (int k = 1; k <= 32; k++) begin
      logic [4:0] a;
      if (k > 1) step();
      wr_en = '0;
      clr   = 1'b0;
      if (k == wr_at) set_wr(0, 5'd9, 32'h0000_0099);
      if (k == clr_at) clr = 1'b1;
      expect_out({name, "_ready"}, 0, (k == 32) ? 32'h1 : 32'h0);
      a = k[4:0];
      if (k < 32) rd_chk(name, a, 32'h0, 5'd9, 32'h0);
    end
    wr_en = '0;
    clr   = 1'b0;
  endtask

  function automatic logic [31:0] fill(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  initial begin
    rst     = 1'b1;
    clr     = 1'b0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("rst_ready", 0, 32'h0);
      rd_chk("rst", 5'd3, 32'h0, 5'd31, 32'h0);
    end
    step();
    rst = 1'b0;
    run_clear("rst_clear", 0, 0);
    read_all_zero("post_rst");

    // Basic write/read.
    step();
    set_wr(0, 5'd5, 32'hDEAD_BEEF);
    step();
    wr_en = '0;
    rd_chk("basic", 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0);
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL basic_direct: got %h", rd_data[31:0]);
    end
    n_checks++;
    if (rd_data[63:32] !== 32'h0) begin
      n_err++;
      $display("FAIL basic_x0_direct: got %h", rd_data[63:32]);
    end

    // x0 protection on both ports.
    step();
    set_wr(0, 5'd0, 32'hFFFF_FFFF);
    set_wr(1, 5'd0, 32'hFFFF_FFFF);
    step();
    wr_en = '0;
    rd_chk("x0", 5'd0, 32'h0, 5'd5, 32'hDEAD_BEEF);
    step();
    rd_chk("x0_others", 5'd1, 32'h0, 5'd31, 32'h0);

    // Collision then independent dual writes.
    step();
    set_wr(0, 5'd7, 32'h11);
    set_wr(1, 5'd7, 32'h22);
    step();
    set_wr(0, 5'd8, 32'h88);
    set_wr(1, 5'd10, 32'hAA);
    rd_chk("collide", 5'd7, 32'h22, 5'd6, 32'h0);
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h22) begin
      n_err++;
      $display("FAIL collide_direct: got %h", rd_data[31:0]);
    end
    step();
    wr_en = '0;
    rd_chk("dual", 5'd8, 32'h88, 5'd10, 32'hAA);
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h88) begin
      n_err++;
      $display("FAIL dual0_direct: got %h", rd_data[31:0]);
    end
    n_checks++;
    if (rd_data[63:32] !== 32'hAA) begin
      n_err++;
      $display("FAIL dual1_direct: got %h", rd_data[63:32]);
    end

    // Same-cycle write/read of x3.
    step();
    set_wr(0, 5'd3, 32'hCAFE);
    rd_chk("bypass_pre", 5'd3, Bypass ? 32'hCAFE : 32'h0, 5'd0, 32'h0);
    step();
    wr_en = '0;
    rd_chk("bypass_post", 5'd3, 32'hCAFE, 5'd7, 32'h22);
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hCAFE) begin
      n_err++;
      $display("FAIL bypass_post_direct: got %h", rd_data[31:0]);
    end

    // Fill x1..x31.
    for (int i = 1; i <= 31; i += 2) begin
      step();
      wr_en = '0;
      set_wr(0, 5'(i), fill(i));
      if (i + 1 <= 31) set_wr(1, 5'(i + 1), fill(i + 1));
    end
    step();
    wr_en = '0;
    rd_chk("fill_a", 5'd1, fill(1), 5'd31, fill(31));
    step();
    rd_chk("fill_b", 5'd9, fill(9), 5'd16, fill(16));

    // Clear request; write to x9 and re-request mid-clear are both ignored.
    step();
    clr = 1'b1;
    expect_out("clr_req_ready", 0, 32'h1);
    rd_chk("clr_req", 5'd9, fill(9), 5'd0, 32'h0);
    step();
    run_clear("clr", 20, 25);
    read_all_zero("post_clr");

    // Reset in the middle of a clear restarts the full count.
    step();
    set_wr(0, 5'd9, 32'h55);
    step();
    wr_en = '0;
    rd_chk("pre_mid", 5'd9, 32'h55, 5'd0, 32'h0);
    clr = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      clr = 1'b0;
      expect_out("mid_ready", 0, 32'h0);
    end
    step();
    rst = 1'b1;
    expect_out("mid_rst_ready", 0, 32'h0);
    step();
    rst = 1'b0;
    run_clear("rst_mid", 0, 0);
    read_all_zero("post_mid");

    step();
    step();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_err++;
      $display("FAIL %s: never checked, expected %h", e.name, e.exp);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
